eq_band_mixer: RTL

//   Downstream stage of the 8-band equalizer. Captures one sample from each of the 8 band filters,

---
 rtl/eq_band_mixer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eq_band_mixer.sv
// Equalizer output stage: captures one sample per band, applies per-band gains through a single
// shared multiplier, then rounds half-up and saturates the sum into one output sample.
module eq_band_mixer #(
    parameter int N_BANDS   = 8,
    parameter int IN_W      = 32,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 12,
    parameter int OUT_W     = 24,
    parameter int BW        = $clog2(N_BANDS)
) (
    input  logic                       clk,
    input  logic                       rst_p,
    input  logic                       ena,
    input  logic [N_BANDS*IN_W-1:0]    band_in,
    input  logic                       band_valid,
    input  logic                       gain_we,
    input  logic [BW-1:0]              gain_addr,
    input  logic [GAIN_W-1:0]          gain_data,
    output logic                       busy,
    output logic [OUT_W-1:0]           y_out,
    output logic                       y_valid,
    output logic                       y_sat,
    output logic                       overrun
);
    localparam int PW    = IN_W + GAIN_W;
    localparam int ACC_W = PW + BW;
    localparam logic signed [GAIN_W-1:0] UNITY    = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;
    localparam logic signed [ACC_W-1:0]  RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (GAIN_FRAC-1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

    state_t                   r_state;
    logic signed [IN_W-1:0]   r_band     [N_BANDS];
    logic signed [GAIN_W-1:0] r_gain     [N_BANDS];
    logic signed [GAIN_W-1:0] r_gain_act [N_BANDS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [BW-1:0]            r_idx;
    logic                     r_busy;
    logic [OUT_W-1:0]         r_y_out;
    logic                     r_y_valid;
    logic                     r_y_sat;
    logic                     r_overrun;

    logic signed [IN_W-1:0]   w_band_sel;
    logic signed [GAIN_W-1:0] w_gain_sel;
    logic signed [PW-1:0]     w_prod;
    logic signed [ACC_W-1:0]  w_acc_rnd;
    logic signed [ACC_W-1:0]  w_rnd;
    logic                     w_fits;
    logic [OUT_W-1:0]         w_y_next;

    assign w_band_sel = r_band[r_idx];
    assign w_gain_sel = r_gain_act[r_idx];
    assign w_prod     = PW'(w_band_sel) * PW'(w_gain_sel);
    assign w_acc_rnd  = r_acc + RND_HALF;
    assign w_rnd      = w_acc_rnd >>> GAIN_FRAC;
    // Result fits when every bit above the output sign bit equals it.
    assign w_fits     = (&w_rnd[ACC_W-1:OUT_W-1]) | ~(|w_rnd[ACC_W-1:OUT_W-1]);
    assign w_y_next   = w_fits ? w_rnd[OUT_W-1:0]
                               : {w_rnd[ACC_W-1], {(OUT_W-1){~w_rnd[ACC_W-1]}}};

    assign busy    = r_busy;
    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign y_sat   = r_y_sat;
    assign overrun = r_overrun;

    // Gain file: written regardless of ena or frame state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BANDS; i++) begin
            if (rst_p) begin
                r_gain[i] <= UNITY;
            end else if (gain_we && (gain_addr == BW'(i))) begin
                r_gain[i] <= gain_data;
            end else begin
                r_gain[i] <= r_gain[i];
            end
        end
    end

    // Frame sequencer: capture, multiply-accumulate one band per cycle, round and saturate.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
            r_y_sat   <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < N_BANDS; i++) begin
                r_band[i]     <= '0;
                r_gain_act[i] <= UNITY;
            end
        end else if (ena) begin
            r_y_valid <= 1'b0;
            r_y_sat   <= 1'b0;
            if (band_valid && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
            case (r_state)
                S_IDLE: begin
                    if (band_valid) begin
                        for (int i = 0; i < N_BANDS; i++) begin
                            r_band[i]     <= band_in[i*IN_W +: IN_W];
                            r_gain_act[i] <= r_gain[i];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_idx == BW'(N_BANDS-1)) begin
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + BW'(1);
                    end
                end
                S_OUT: begin
                    r_y_out   <= w_y_next;
                    r_y_valid <= 1'b1;
                    r_y_sat   <= ~w_fits;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end else begin
            r_y_valid <= 1'b0;
            r_y_sat   <= 1'b0;
        end
    end
endmodule
